// File: rtl/weight_stream_bram.sv
// weight_stream_bram: a DATA_W x DEPTH weight RAM with a single-cycle write port
// and a burst-read engine. The engine streams LEN consecutive words from BASE and
// wraps DEPTH-1 -> 0. Words leave through a 2-entry FIFO under valid/ready.
// Contents are loaded through the write port before streaming.
module weight_stream_bram #(
    parameter int    DATA_W    = 16,
    parameter int    DEPTH     = 28,
    parameter int    ADDR_W    = 5,
    parameter string INIT_FILE = "weight.txt"
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W:0]   LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              DO_VALID,
    input  logic              DO_READY,
    output logic [DATA_W-1:0] DO,
    output logic              DO_LAST
);

    localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_rd_data;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_head;
    logic [1:0]        r_count;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_start_ok;
    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_used;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_tail;
    logic [ADDR_W-1:0] w_next_addr;

    // A request is legal only if it starts inside the RAM and asks for 1..DEPTH words
    assign w_start_ok = ({1'b0, BASE} < LP_DEPTH) && (LEN != '0) && (LEN <= LP_DEPTH);

    // FIFO head drives the stream; a pop happens when the head word is handed over
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && DO_READY;

    // Issue a read only if the word it returns is guaranteed a FIFO slot, counting
    // the slot freed by a pop on this same edge so a ready consumer gets one word per cycle
    assign w_used       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == S_RUN) && (w_used < 3'd2);
    assign w_issue_last = w_issue && ((r_issued + (ADDR_W+1)'(1)) == r_len);

    // Wrap by compare so DEPTH need not be a power of two
    assign w_next_addr = (r_rd_addr == LP_LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);

    // Slot that receives the returning read word
    assign w_tail = r_head ^ r_count[0];

    // Burst control FSM: accept/reject requests, count issued reads, finish on last accept
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_len     <= '0;
            r_issued  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        if (w_start_ok) begin
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_rd_addr <= BASE;
                            r_len     <= LEN;
                            r_issued  <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_issued  <= r_issued + (ADDR_W+1)'(1);
                        r_rd_addr <= w_next_addr;
                        if (w_issue_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && r_fifo_last[r_head]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Block RAM: write port plus read-first synchronous read, never reset
    always_ff @(posedge CLK) begin
        if (WR_EN && ({1'b0, WR_ADDR} < LP_DEPTH)) begin
            r_mem[WR_ADDR] <= WR_DATA;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    // Track the single read in flight and whether it carries the last-word tag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
        end
    end

    // 2-entry output FIFO: push returning read data, pop on handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_head         <= 1'b0;
            r_count        <= '0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[w_tail] <= r_rd_data;
                r_fifo_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign DO_VALID = w_valid;
    assign DO       = r_fifo_data[r_head];
    assign DO_LAST  = w_valid && r_fifo_last[r_head];

endmodule

// File: tb/tb_weight_stream_bram.sv
// tb_weight_stream_bram: directed bench for weight_stream_bram. A behavioural model
// (shadow RAM, expected-word queue, busy/err/done flags) is checked every cycle,
// and literal expectations pin latency, first words and pulse counts.
module tb_weight_stream_bram;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              START;
    logic [ADDR_W-1:0] BASE;
    logic [ADDR_W:0]   LEN;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic              DO_VALID;
    logic              DO_READY;
    logic [DATA_W-1:0] DO;
    logic              DO_LAST;

    int checkCount = 0;
    int passCount  = 0;

    logic [DATA_W-1:0] mMem [DEPTH];
    logic [DATA_W-1:0] expQ [$];
    bit                mBusy     = 1'b0;
    bit                mErr      = 1'b0;
    bit                mDone     = 1'b0;
    bit                prevStall = 1'b0;
    logic [DATA_W-1:0] prevDo    = '0;
    int                wordsSeen = 0;
    int                doneSeen  = 0;

    weight_stream_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .START    (START),
        .BASE     (BASE),
        .LEN      (LEN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .DO_VALID (DO_VALID),
        .DO_READY (DO_READY),
        .DO       (DO),
        .DO_LAST  (DO_LAST)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeWord(input int addr, input logic [DATA_W-1:0] data);
        WR_EN   = 1'b1;
        WR_ADDR = ADDR_W'(addr);
        WR_DATA = data;
        tick();
        WR_EN = 1'b0;
        if (addr < DEPTH) mMem[addr] = data;
    endtask

    // Expected stream for a burst: consecutive words modulo DEPTH from the shadow RAM
    task automatic pushBurst(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            expQ.push_back(mMem[(base + k) % DEPTH]);
        end
    endtask

    task automatic applyStimulus(input int base, input int len);
        START = 1'b1;
        BASE  = ADDR_W'(base);
        LEN   = (ADDR_W+1)'(len);
        tick();
        START = 1'b0;
    endtask

    // Called right after the START edge: pins the 2-cycle latency and the first word
    task automatic checkFirst(input string name, input logic [DATA_W-1:0] first);
        @(negedge CLK);
        checkOutput({name, "_lat0"}, DO_VALID, 0);
        checkOutput({name, "_busy"}, BUSY, 1);
        tick();
        @(negedge CLK);
        checkOutput({name, "_lat1"}, DO_VALID, 0);
        tick();
        @(negedge CLK);
        checkOutput({name, "_lat2"}, DO_VALID, 1);
        checkOutput({name, "_first"}, DO, first);
    endtask

    task automatic waitIdle(input string name, input int maxCycles, input bit toggle);
        bit finished = 1'b0;
        for (int c = 0; c < maxCycles && !finished; c++) begin
            if (toggle) DO_READY = (c % 3 == 0);
            tick();
            if (BUSY == 1'b0 && expQ.size() == 0) finished = 1'b1;
        end
        DO_READY = 1'b1;
        checkOutput({name, "_timeout"}, finished, 1);
        tick();
        tick();
    endtask

    // Per-cycle compare against the behavioural model, sampled on the falling edge
    always @(negedge CLK) begin
        bit legal;
        bit accLast;
        if (!RST_N) begin
            checkOutput("rst_busy", BUSY, 0);
            checkOutput("rst_done", DONE, 0);
            checkOutput("rst_err", ERR, 0);
            checkOutput("rst_valid", DO_VALID, 0);
            checkOutput("rst_last", DO_LAST, 0);
            checkOutput("rst_do", DO, 0);
            mBusy     = 1'b0;
            mErr      = 1'b0;
            mDone     = 1'b0;
            prevStall = 1'b0;
            expQ.delete();
        end else begin
            checkOutput("busy", BUSY, mBusy);
            checkOutput("err", ERR, mErr);
            checkOutput("done", DONE, mDone);
            if (DONE) doneSeen++;
            if (prevStall) begin
                checkOutput("stall_valid", DO_VALID, 1);
                checkOutput("stall_hold", DO, prevDo);
            end
            if (DO_VALID && !mBusy) checkOutput("valid_idle", DO_VALID, 0);
            accLast = 1'b0;
            if (DO_VALID && DO_READY) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_word", expQ.size(), 1);
                end else begin
                    checkOutput("data", DO, expQ[0]);
                    checkOutput("last", DO_LAST, (expQ.size() == 1));
                    accLast = (expQ.size() == 1);
                    void'(expQ.pop_front());
                    wordsSeen++;
                end
            end
            legal = (BASE < DEPTH) && (LEN >= 1) && (LEN <= DEPTH);
            mErr  = !mBusy && START && !legal;
            mDone = accLast;
            if (accLast) mBusy = 1'b0;
            else if (!mBusy && START && legal) mBusy = 1'b1;
            prevStall = DO_VALID && !DO_READY;
            prevDo    = DO;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int w0;
        int d0;
        int badBase [3];
        int badLen  [3];
        badBase = '{0, 0, 28};
        badLen  = '{0, 29, 4};

        RST_N    = 1'b0;
        WR_EN    = 1'b0;
        WR_ADDR  = '0;
        WR_DATA  = '0;
        START    = 1'b0;
        BASE     = '0;
        LEN      = '0;
        DO_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();

        $display("[TB] loading mem[i] = i+1");
        for (int i = 0; i < DEPTH; i++) writeWord(i, DATA_W'(i + 1));
        tick();

        $display("[TB] basic burst BASE=0 LEN=4");
        w0 = wordsSeen; d0 = doneSeen;
        pushBurst(0, 4);
        applyStimulus(0, 4);
        checkFirst("t1", 16'd1);
        waitIdle("t1", 40, 1'b0);
        checkOutput("t1_words", wordsSeen - w0, 4);
        checkOutput("t1_done", doneSeen - d0, 1);

        $display("[TB] wrap burst BASE=26 LEN=5");
        w0 = wordsSeen; d0 = doneSeen;
        pushBurst(26, 5);
        applyStimulus(26, 5);
        checkFirst("t2", 16'd27);
        waitIdle("t2", 40, 1'b0);
        checkOutput("t2_words", wordsSeen - w0, 5);
        checkOutput("t2_done", doneSeen - d0, 1);

        $display("[TB] backpressure BASE=0 LEN=6");
        w0 = wordsSeen; d0 = doneSeen;
        pushBurst(0, 6);
        applyStimulus(0, 6);
        waitIdle("t3", 80, 1'b1);
        checkOutput("t3_words", wordsSeen - w0, 6);
        checkOutput("t3_done", doneSeen - d0, 1);

        $display("[TB] illegal requests");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(badBase[i], badLen[i]);
            @(negedge CLK);
            checkOutput("t4_err", ERR, 1);
            checkOutput("t4_busy", BUSY, 0);
            tick();
            @(negedge CLK);
            checkOutput("t4_err_once", ERR, 0);
            checkOutput("t4_novalid", DO_VALID, 0);
            tick();
        end

        $display("[TB] START while busy is ignored");
        w0 = wordsSeen; d0 = doneSeen;
        pushBurst(0, 4);
        applyStimulus(0, 4);
        applyStimulus(10, 3);
        waitIdle("t4b", 40, 1'b0);
        checkOutput("t4b_words", wordsSeen - w0, 4);
        checkOutput("t4b_done", doneSeen - d0, 1);

        $display("[TB] write collision during burst BASE=0 LEN=8");
        pushBurst(0, 8);
        expQ[6] = 16'hBEEF;
        applyStimulus(0, 8);
        tick();
        tick();
        writeWord(2, 16'hBEEF);
        writeWord(6, 16'hBEEF);
        waitIdle("t5", 40, 1'b0);
        writeWord(2, 16'd3);
        writeWord(6, 16'd7);
        tick();

        $display("[TB] reset mid-burst");
        pushBurst(0, 6);
        applyStimulus(0, 6);
        repeat (3) tick();
        RST_N = 1'b0;
        @(negedge CLK);
        checkOutput("t6_rst_busy", BUSY, 0);
        checkOutput("t6_rst_valid", DO_VALID, 0);
        tick();
        RST_N = 1'b1;
        d0 = doneSeen;
        repeat (4) tick();
        checkOutput("t6_nodone", doneSeen - d0, 0);
        w0 = wordsSeen;
        pushBurst(0, 2);
        applyStimulus(0, 2);
        checkFirst("t6", 16'd1);
        waitIdle("t6", 40, 1'b0);
        checkOutput("t6_words", wordsSeen - w0, 2);
        checkOutput("t6_done", doneSeen - d0, 1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
